// File: rtl/linear_recurrence_gen.sv
// linear_recurrence_gen: streams len terms of x[n] = x[n-1] + ... + x[n-k] from programmable seeds.
// Build option: define LINREC_SATURATE_EN to clamp overflowing terms to all-ones instead of wrapping.
//
// state | meaning
// IDLE  | waiting for a legal start; stream outputs idle
// RUN   | emitting terms; ends on last handshake or abort
module linear_recurrence_gen #(
  parameter int SEQ_BITS  = 32,
  parameter int MAX_ORDER = 4,
  parameter int LEN_BITS  = 16
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic [LEN_BITS-1:0]                  len,
  input  logic [$clog2(MAX_ORDER+1)-1:0]       order,
  input  logic [MAX_ORDER*SEQ_BITS-1:0]        seed,
  output logic [SEQ_BITS-1:0]                  m_data,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic                                 m_last,
  output logic [LEN_BITS-1:0]                  m_index,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 overflow
);

  localparam int ORD_W = $clog2(MAX_ORDER+1);
  localparam int SUM_W = SEQ_BITS + $clog2(MAX_ORDER);
  localparam int WIN_W = MAX_ORDER*SEQ_BITS;

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [WIN_W-1:0]      win_q, win_step, win_seed;
  logic [LEN_BITS-1:0]   len_q;
  logic [ORD_W-1:0]      order_q;
  logic [SUM_W-1:0]      sum;
  logic [SEQ_BITS-1:0]   term;
  logic                  sum_ovf, term_in_range;
  logic                  order_ok, hs, accept, end_run;

  assign busy     = (state_q == RUN);
  assign m_valid  = (state_q == RUN);
  assign m_data   = win_q[SEQ_BITS-1:0];
  assign m_last   = m_valid && (m_index == len_q - 1'b1);
  assign hs       = m_valid && m_ready;
  assign order_ok = (order >= ORD_W'(2)) && (order <= ORD_W'(MAX_ORDER));
  // Term produced by this handshake has index m_index+k; only those that will be emitted flag overflow.
  assign term_in_range = ({1'b0, m_index} + (LEN_BITS+1)'(order_q)) < {1'b0, len_q};

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    end_run = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (len != '0) && order_ok) begin
          accept  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort || (hs && m_last)) begin
          end_run = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Window slots at and above k are always zero, so summing every slot gives the order-k sum.
  always_comb begin
    sum = '0;
    for (int i = 0; i < MAX_ORDER; i++)
      sum += SUM_W'(win_q[i*SEQ_BITS +: SEQ_BITS]);
    sum_ovf = |sum[SUM_W-1:SEQ_BITS];
`ifdef LINREC_SATURATE_EN
    term = sum_ovf ? '1 : sum[SEQ_BITS-1:0];
`else
    term = sum[SEQ_BITS-1:0];
`endif
    win_step = win_q >> SEQ_BITS;
    for (int i = 0; i < MAX_ORDER; i++)
      if (ORD_W'(i) == order_q - 1'b1)
        win_step[i*SEQ_BITS +: SEQ_BITS] = term;
    win_seed = '0;
    for (int i = 0; i < MAX_ORDER; i++)
      if (ORD_W'(i) < order)
        win_seed[i*SEQ_BITS +: SEQ_BITS] = seed[i*SEQ_BITS +: SEQ_BITS];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      win_q    <= '0;
      len_q    <= '0;
      order_q  <= '0;
      m_index  <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= end_run;
      if (accept) begin
        win_q    <= win_seed;
        len_q    <= len;
        order_q  <= order;
        m_index  <= '0;
        overflow <= 1'b0;
      end else if (hs) begin
        win_q   <= win_step;
        m_index <= m_index + 1'b1;
        if (sum_ovf && term_in_range)
          overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_linear_recurrence_gen.sv
// Scoreboard bench for linear_recurrence_gen at SEQ_BITS=8 so wrap/saturation is reachable quickly.
module tb_linear_recurrence_gen;

  localparam int SB = 8;
  localparam int MO = 4;
  localparam int LB = 16;
  localparam int MAXV = (1 << SB) - 1;

  typedef struct packed {
    logic [SB-1:0] d;
    logic [LB-1:0] idx;
    logic          l;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n, start, abort;
  logic [LB-1:0]    len;
  logic [2:0]       order;
  logic [MO*SB-1:0] seed;
  logic [SB-1:0]    m_data;
  logic             m_valid, m_last, busy, done, overflow;
  logic             m_ready = 1'b0;
  logic [LB-1:0]    m_index;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  bit   mon_en  = 1'b0;
  bit   ready_rnd = 1'b0;
  bit   prev_stall = 1'b0;
  logic [SB-1:0] prev_d;
  logic [LB-1:0] prev_i;
  logic          prev_l;

  linear_recurrence_gen #(.SEQ_BITS(SB), .MAX_ORDER(MO), .LEN_BITS(LB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len), .order(order),
    .seed(seed), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
    .m_index(m_index), .busy(busy), .done(done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    m_ready = ready_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (prev_stall && m_valid) begin
        check("hold_data", 32'(m_data), 32'(prev_d));
        check("hold_index", 32'(m_index), 32'(prev_i));
        check("hold_last", 32'(m_last), 32'(prev_l));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_term", 32'(m_index), 32'hFFFF_FFFF);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("data", 32'(m_data), 32'(e.d));
          check("index", 32'(m_index), 32'(e.idx));
          check("last", 32'(m_last), 32'(e.l));
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_d = m_data;
      prev_i = m_index;
      prev_l = m_last;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Reference recurrence; returns whether any emitted computed term overflowed.
  task automatic push_model(input int k, input int s0, input int s1, input int s2, input int s3,
                            input int n, output bit ovf);
    int x[$];
    int s[4];
    int v;
    exp_t e;
    s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
    ovf = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i < k) begin
        v = s[i];
      end else begin
        v = 0;
        for (int j = 1; j <= k; j++) v += x[i-j];
        if (v > MAXV) begin
          ovf = 1'b1;
`ifdef LINREC_SATURATE_EN
          v = MAXV;
`else
          v = v % (MAXV + 1);
`endif
        end
      end
      x.push_back(v);
      e.d = SB'(v);
      e.idx = LB'(i);
      e.l = (i == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic pulse_start(input int k, input int s0, input int s1, input int s2, input int s3,
                             input int n, input bit with_abort);
    start = 1'b1;
    abort = with_abort;
    len   = LB'(n);
    order = 3'(k);
    seed  = {SB'(s3), SB'(s2), SB'(s1), SB'(s0)};
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (done) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    check({tag, "_done"}, 32'(seen), 32'd1);
  endtask

  task automatic run_seq(input string tag, input int k, input int s0, input int s1, input int s2,
                         input int s3, input int n, input bit rnd, input bit with_abort);
    bit eo;
    push_model(k, s0, s1, s2, s3, n, eo);
    ready_rnd = rnd;
    pulse_start(k, s0, s1, s2, s3, n, with_abort);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_first"}, 32'(m_data), 32'(SB'(s0)));
    wait_done(tag);
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_ovf"}, 32'(overflow), 32'(eo));
    check({tag, "_idle"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    exp_q.delete();
    ready_rnd = 1'b0;
  endtask

  task automatic try_illegal(input string tag, input int k, input int n);
    bit seen = 1'b0;
    pulse_start(k, 3, 4, 5, 6, n, 1'b0);
    for (int c = 0; c < 6; c++) begin
      if (busy || m_valid || done) seen = 1'b1;
      @(posedge clk); #1;
    end
    check(tag, 32'(seen), 32'd0);
  endtask

  task automatic wait_index(input int n);
    bit ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (m_valid && m_index == LB'(n)) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("wait_index", 32'(ok), 32'd1);
  endtask

  initial begin
    bit eo;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; len = '0; order = '0; seed = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_index", 32'(m_index), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk); #1;

    run_seq("fib10", 2, 0, 1, 0, 0, 10, 1'b0, 1'b0);
    run_seq("trib8", 3, 0, 0, 1, 0, 8, 1'b0, 1'b0);
    run_seq("lucas5", 2, 2, 1, 0, 0, 5, 1'b0, 1'b0);
    run_seq("fib20_bp", 2, 0, 1, 0, 0, 20, 1'b1, 1'b0);
    run_seq("fib15_wrap", 2, 0, 1, 0, 0, 15, 1'b0, 1'b0);
    run_seq("tetra12_bp", 4, 1, 1, 1, 1, 12, 1'b1, 1'b0);
    run_seq("seeds_only", 3, 5, 6, 7, 0, 2, 1'b0, 1'b0);
    run_seq("len1", 2, 9, 4, 0, 0, 1, 1'b1, 1'b0);

    try_illegal("len0_ignored", 2, 0);
    try_illegal("order1_ignored", 1, 5);
    try_illegal("order5_ignored", 5, 5);

    // start while busy must not disturb the run; abort at index 4 ends it
    push_model(2, 0, 1, 0, 0, 10, eo);
    pulse_start(2, 0, 1, 0, 0, 10, 1'b0);
    wait_index(2);
    start = 1'b1; len = LB'(3); order = 3'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_index(4);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_valid", 32'(m_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd1);
    check("abort_remaining", 32'(exp_q.size()), 32'd5);
    exp_q.delete();
    @(posedge clk); #1;
    check("abort_done_pulse", 32'(done), 32'd0);

    run_seq("start_abort_idle", 2, 0, 1, 0, 0, 3, 1'b0, 1'b1);

    // synchronous reset mid-run clears everything including a set overflow
    mon_en = 1'b0;
    pulse_start(2, 200, 100, 0, 0, 10, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_ovf", 32'(overflow), 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mrst_valid", 32'(m_valid), 32'd0);
    check("mrst_busy", 32'(busy), 32'd0);
    check("mrst_done", 32'(done), 32'd0);
    check("mrst_ovf", 32'(overflow), 32'd0);
    check("mrst_data", 32'(m_data), 32'd0);
    check("mrst_index", 32'(m_index), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("mrst_no_done", 32'(done), 32'd0);
    mon_en = 1'b1;

    run_seq("fib_after_rst", 2, 0, 1, 0, 0, 6, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
